// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between the decode/ALU-control stage (master)
// and the shift sequencer (slave).
// Optional feature macro: SHIFT_ROTATE_EN adds the rotate request bit.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] source;
  logic [AMT_W-1:0] amount;
  logic             dir;
`ifdef SHIFT_ROTATE_EN
  logic             rotate;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

`ifdef SHIFT_ROTATE_EN
  modport master (output start, source, amount, dir, rotate,
                  input  ready, busy, done, result, carry_out);
  modport slave  (input  start, source, amount, dir, rotate,
                  output ready, busy, done, result, carry_out);
`else
  modport master (output start, source, amount, dir,
                  input  ready, busy, done, result, carry_out);
  modport slave  (input  start, source, amount, dir,
                  output ready, busy, done, result, carry_out);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: one 1-bit shift per clock, result handed over
// with a single-cycle done pulse.
// Optional feature macro: SHIFT_ROTATE_EN (circular rotate instead of zero fill).
//
// state | meaning
// IDLE  | ready for a new operation
// SHIFT | one bit shifted per cycle, count decrementing
// DONE  | result/carry_out valid, done pulsed for this one cycle
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic              clk,
  input logic              reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [AMT_W-1:0] count_q;
  logic             dir_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ready, busy, done;
  logic             accept;
  logic             last_shift;
  logic             out_bit;
  logic             fill;
  logic [WIDTH-1:0] acc_shf;

`ifdef SHIFT_ROTATE_EN
  logic rot_q;
`endif

  assign accept     = (state_q == IDLE) && bus.start;
  assign last_shift = (state_q == SHIFT) && (count_q == AMT_W'(1));

  // One-bit shift of the accumulator; fill is zero unless rotating.
  always_comb begin
    out_bit = dir_q ? acc_q[0] : acc_q[WIDTH-1];
`ifdef SHIFT_ROTATE_EN
    fill = rot_q & out_bit;
`else
    fill = 1'b0;
`endif
    if (dir_q) acc_shf = {fill, acc_q[WIDTH-1:1]};
    else       acc_shf = {acc_q[WIDTH-2:0], fill};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = (bus.amount == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-cycle shift, and result update on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q    <= 1'b0;
`endif
    end else if (accept) begin
      acc_q   <= bus.source;
      count_q <= bus.amount;
      dir_q   <= bus.dir;
      carry_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q   <= bus.rotate;
`endif
      // Zero-length op goes straight to DONE with the operand untouched.
      if (bus.amount == '0) result_q <= bus.source;
    end else if (state_q == SHIFT) begin
      acc_q   <= acc_shf;
      count_q <= count_q - AMT_W'(1);
      if (last_shift) begin
        result_q <= acc_shf;
        carry_q  <= out_bit;
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic
// reference model.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] prev_res;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift result from plain arithmetic on the whole operand.
  function automatic void model(input logic [7:0] src, input int amt, input logic d,
                                input logic rot, output logic [7:0] res, output logic car);
    int s;
    s = int'(src);
    if (amt == 0) begin
      res = src;
      car = 1'b0;
    end else if (!d) begin
      res = 8'(((s << amt) & 255) | (rot ? (s >> (8 - amt)) : 0));
      car = 1'(((s >> (8 - amt)) & 1));
    end else begin
      res = 8'((s >> amt) | (rot ? ((s << (8 - amt)) & 255) : 0));
      car = 1'(((s >> (amt - 1)) & 1));
    end
  endfunction

  task automatic drive_rot(input logic r);
`ifdef SHIFT_ROTATE_EN
    bus.rotate = r;
`else
    if (r) $display("rotate request ignored in this build");
`endif
  endtask

  // One complete operation; noise scrambles start/operands after acceptance.
  task automatic run_op(input logic [7:0] src, input int amt, input logic d,
                        input logic rot, input bit noise);
    logic [7:0] e_res;
    logic       e_car;
    model(src, amt, d, rot, e_res, e_car);
    check_eq("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start  = 1'b1;
    bus.source = src;
    bus.amount = 3'(amt);
    bus.dir    = d;
    drive_rot(rot);
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= amt + 1; c++) begin
      check_eq("busy", 32'(bus.busy), 32'(c <= amt));
      check_eq("done", 32'(bus.done), 32'(c == amt + 1));
      check_eq("ready_during_op", 32'(bus.ready), 32'd0);
      if (c <= amt) begin
        check_eq("result_hold", 32'(bus.result), 32'(prev_res));
      end else begin
        check_eq("result", 32'(bus.result), 32'(e_res));
        check_eq("carry_out", 32'(bus.carry_out), 32'(e_car));
      end
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.source = 8'($urandom);
        bus.amount = 3'($urandom);
        bus.dir    = 1'($urandom);
        drive_rot(1'($urandom) & rot);
      end
      step();
    end
    bus.start = 1'b0;
    check_eq("done_single", 32'(bus.done), 32'd0);
    check_eq("ready_after", 32'(bus.ready), 32'd1);
    check_eq("result_held", 32'(bus.result), 32'(e_res));
    prev_res = e_res;
  endtask

  initial begin
    logic r;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.source = '0;
    bus.amount = '0;
    bus.dir    = 1'b0;
    drive_rot(1'b0);
    prev_res   = 8'h00;
    step();
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_carry", 32'(bus.carry_out), 32'd0);
    step();
    reset = 1'b0;
    step();

    run_op(8'h96, 3, 1'b0, 1'b0, 1'b0);
    run_op(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    run_op(8'h81, 1, 1'b1, 1'b0, 1'b0);
    run_op(8'hFF, 7, 1'b0, 1'b0, 1'b0);
    run_op(8'h01, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("no_extra_done", 32'(bus.done), 32'd0);
    end

    // Reset during the second SHIFT cycle abandons the op.
    bus.start  = 1'b1;
    bus.source = 8'h96;
    bus.amount = 3'd5;
    bus.dir    = 1'b0;
    drive_rot(1'b0);
    step();
    bus.start = 1'b0;
    step();
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_result", 32'(bus.result), 32'd0);
    check_eq("abort_carry", 32'(bus.carry_out), 32'd0);
    prev_res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check_eq("abort_no_done", 32'(bus.done), 32'd0);
      step();
    end

`ifdef SHIFT_ROTATE_EN
    run_op(8'h81, 1, 1'b0, 1'b1, 1'b0);
    run_op(8'h81, 1, 1'b0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef SHIFT_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      run_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), r, 1'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
